// File: rtl/cnn_pkg.sv
// Shared types and default layer tables for the CNN layer sequencer.
package cnn_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CONV = 2'd1,
        POOL = 2'd2,
        FC   = 2'd3
    } layer_type_e;

    typedef logic [2:0] seq_state_e;
    localparam seq_state_e IDLE  = 3'd0;
    localparam seq_state_e CLEAR = 3'd1;
    localparam seq_state_e RUN   = 3'd2;
    localparam seq_state_e FLUSH = 3'd3;
    localparam seq_state_e ERR   = 3'd4;

    localparam logic [1:0] MAC_CONV1 = 2'd0;
    localparam logic [1:0] MAC_CONV2 = 2'd1;
    localparam logic [1:0] MAC_FC    = 2'd2;

    localparam int CTRL_ABORT = 0;

    // Layer 0 sits in the least significant field.
    localparam logic [11:0] DEF_LAYER_TYPE = {FC, POOL, CONV, POOL, CONV, LOAD};
    localparam logic [11:0] DEF_MAC_SEL    = {MAC_FC, MAC_CONV1, MAC_CONV2,
                                              MAC_CONV1, MAC_CONV1, MAC_CONV1};

endpackage

// File: rtl/cnn_watchdog.sv
// RUN-cycle watchdog: cleared by clr_i, counts on inc_i, saturates at TIMEOUT_CYC.
// expired_o is combinational from the count and flags the last allowed RUN cycle.
module cnn_watchdog #(
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != WD_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == WD_LAST);

endmodule

// File: rtl/cnn_layer_seq.sv
// Sequences CNN layers from a host command: CLEAR -> RUN -> FLUSH per layer, optional chaining.
// Outputs are registered from next-state decode, so they line up with the state register.
module cnn_layer_seq
    import cnn_pkg::*;
#(
    parameter int                        NUM_LAYERS  = 6,
    parameter int                        CTRL_W      = 8,
    parameter logic [2*NUM_LAYERS-1:0]   LAYER_TYPE  = DEF_LAYER_TYPE,
    parameter logic [2*NUM_LAYERS-1:0]   MAC_SEL     = DEF_MAC_SEL,
    parameter int                        FLUSH_CYC   = 3,
    parameter int                        TIMEOUT_CYC = 2**20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CTRL_W-1:0]     ctrl,
    input  logic                  auto_run,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [CTRL_W-1:0]     return_ctrl,
    output logic                  busy,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [NUM_LAYERS-1:0] layer_rst,
    output logic                  mac_enable,
    output logic                  rMAC,
    output logic                  pooling_layer,
    output logic [1:0]            mac_layer,
    output logic                  timeout
);

    localparam int         CUR_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);

    seq_state_e        state_q, state_d;
    logic [CUR_W-1:0]  cur_q, cur_d;
    logic              auto_q, auto_d;
    logic [3:0]        flush_q, flush_d;
    logic [CTRL_W-1:0] ret_d;
    logic              tmo_d;
    logic              wd_expired;
    logic              cmd_abort, cmd_valid;

    logic                  active_d;
    layer_type_e           typ_d;
    logic [1:0]            sel_d;
    logic [NUM_LAYERS-1:0] onehot_d;
    logic                  busy_d, mac_on_d, pool_on_d;
    logic [NUM_LAYERS-1:0] en_d, rst_d;
    logic [1:0]            mac_layer_d;

    assign cmd_abort = (ctrl == CTRL_W'(CTRL_ABORT));
    assign cmd_valid = !cmd_abort && (ctrl <= CTRL_W'(NUM_LAYERS)) && (ctrl != return_ctrl);

    cnn_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (state_q == CLEAR),
        .inc_i     (state_q == RUN),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        auto_d  = auto_q;
        flush_d = flush_q;
        ret_d   = return_ctrl;
        tmo_d   = timeout;
        if (cmd_abort) begin
            state_d = IDLE;
            ret_d   = '0;
            tmo_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_d   = CUR_W'(ctrl - 1'b1);
                        auto_d  = auto_run;
                        state_d = CLEAR;
                    end
                end
                CLEAR: state_d = RUN;
                RUN: begin
                    // A done on the expiry cycle still completes the layer.
                    if (layer_done[cur_q]) begin
                        flush_d = '0;
                        state_d = FLUSH;
                    end else if (wd_expired) begin
                        tmo_d   = 1'b1;
                        state_d = ERR;
                    end
                end
                FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        ret_d = CTRL_W'(int'(cur_q) + 1);
                        if (auto_q && (int'(cur_q) + 1 < NUM_LAYERS)) begin
                            cur_d   = cur_q + 1'b1;
                            state_d = CLEAR;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        flush_d = flush_q + 1'b1;
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        active_d    = (state_d == RUN) || (state_d == FLUSH);
        typ_d       = layer_type_e'(LAYER_TYPE[2*int'(cur_d) +: 2]);
        sel_d       = MAC_SEL[2*int'(cur_d) +: 2];
        onehot_d    = NUM_LAYERS'(1) << cur_d;
        busy_d      = active_d || (state_d == CLEAR);
        en_d        = (state_d == RUN) ? onehot_d : '0;
        rst_d       = active_d ? ~onehot_d : '1;
        mac_on_d    = active_d && ((typ_d == CONV) || (typ_d == FC));
        pool_on_d   = active_d && (typ_d == POOL);
        mac_layer_d = active_d ? sel_d : 2'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            auto_q        <= 1'b0;
            flush_q       <= '0;
            return_ctrl   <= '0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
            layer_en      <= '0;
            layer_rst     <= '1;
            mac_enable    <= 1'b0;
            rMAC          <= 1'b1;
            pooling_layer <= 1'b0;
            mac_layer     <= 2'd0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            auto_q        <= auto_d;
            flush_q       <= flush_d;
            return_ctrl   <= ret_d;
            timeout       <= tmo_d;
            busy          <= busy_d;
            layer_en      <= en_d;
            layer_rst     <= rst_d;
            mac_enable    <= mac_on_d;
            rMAC          <= !mac_on_d;
            pooling_layer <= pool_on_d;
            mac_layer     <= mac_layer_d;
        end
    end

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq with hand-computed expectations (TIMEOUT_CYC=16).
module tb_cnn_layer_seq;

    logic       clk;
    logic       reset;
    logic [7:0] ctrl;
    logic       auto_run;
    logic [5:0] layer_done;
    logic [7:0] return_ctrl;
    logic       busy;
    logic [5:0] layer_en;
    logic [5:0] layer_rst;
    logic       mac_enable;
    logic       rMAC;
    logic       pooling_layer;
    logic [1:0] mac_layer;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_ml [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};

    cnn_layer_seq #(
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl          (ctrl),
        .auto_run      (auto_run),
        .layer_done    (layer_done),
        .return_ctrl   (return_ctrl),
        .busy          (busy),
        .layer_en      (layer_en),
        .layer_rst     (layer_rst),
        .mac_enable    (mac_enable),
        .rMAC          (rMAC),
        .pooling_layer (pooling_layer),
        .mac_layer     (mac_layer),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_ret"},   32'(return_ctrl),   32'h0);
        chk({tag, "_busy"},  32'(busy),          32'h0);
        chk({tag, "_en"},    32'(layer_en),      32'h0);
        chk({tag, "_rst"},   32'(layer_rst),     32'h3f);
        chk({tag, "_mac"},   32'(mac_enable),    32'h0);
        chk({tag, "_rmac"},  32'(rMAC),          32'h1);
        chk({tag, "_pool"},  32'(pooling_layer), 32'h0);
        chk({tag, "_ml"},    32'(mac_layer),     32'h0);
        chk({tag, "_tmo"},   32'(timeout),       32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        ctrl       = 8'd0;
        auto_run   = 1'b0;
        layer_done = 6'd0;
        ticks(2);
        chk_rst_vals("reset");
        reset = 1'b1;
        tick();

        // Single step of conv1
        ctrl = 8'd2;
        tick();
        chk("c1_clear_busy", 32'(busy), 32'h1);
        chk("c1_clear_en", 32'(layer_en), 32'h0);
        chk("c1_clear_rmac", 32'(rMAC), 32'h1);
        chk("c1_clear_rst", 32'(layer_rst), 32'h3f);
        tick();
        chk("c1_run_en", 32'(layer_en), 32'h02);
        chk("c1_run_mac", 32'(mac_enable), 32'h1);
        chk("c1_run_rmac", 32'(rMAC), 32'h0);
        chk("c1_run_ml", 32'(mac_layer), 32'h0);
        chk("c1_run_rst", 32'(layer_rst), 32'h3d);
        ticks(9);
        layer_done = 6'b000010;
        tick();
        layer_done = 6'd0;
        chk("c1_flush_en", 32'(layer_en), 32'h0);
        chk("c1_flush_mac", 32'(mac_enable), 32'h1);
        chk("c1_flush_busy", 32'(busy), 32'h1);
        ticks(2);
        chk("c1_flush_ret", 32'(return_ctrl), 32'h0);
        chk("c1_flush_busy2", 32'(busy), 32'h1);
        tick();
        chk("c1_done_ret", 32'(return_ctrl), 32'h2);
        chk("c1_done_busy", 32'(busy), 32'h0);
        chk("c1_done_rst", 32'(layer_rst), 32'h3f);
        chk("c1_done_rmac", 32'(rMAC), 32'h1);

        // Same layer again without abort, then out-of-range command
        ticks(2);
        chk("rerun_ignored", 32'(busy), 32'h0);
        ctrl = 8'd7;
        ticks(2);
        chk("cmd7_busy", 32'(busy), 32'h0);
        chk("cmd7_ret", 32'(return_ctrl), 32'h2);

        // Auto chain through all layers
        ctrl = 8'd0;
        tick();
        chk("chain_pre_ret", 32'(return_ctrl), 32'h0);
        ctrl     = 8'd1;
        auto_run = 1'b1;
        tick();
        ctrl     = 8'd7;
        auto_run = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("chain%0d_en", k), 32'(layer_en), 32'(1 << k));
            chk($sformatf("chain%0d_pool", k), 32'(pooling_layer), 32'((k == 2) || (k == 4)));
            chk($sformatf("chain%0d_mac", k), 32'(mac_enable), 32'((k == 1) || (k == 3) || (k == 5)));
            chk($sformatf("chain%0d_ml", k), 32'(mac_layer), 32'(exp_ml[k]));
            ticks(4);
            layer_done = 6'(1 << k);
            tick();
            layer_done = 6'd0;
            ticks(3);
            chk($sformatf("chain%0d_ret", k), 32'(return_ctrl), 32'(k + 1));
            if (k < 5) begin
                chk($sformatf("chain%0d_clear_busy", k), 32'(busy), 32'h1);
                chk($sformatf("chain%0d_clear_en", k), 32'(layer_en), 32'h0);
                tick();
            end
        end
        chk("chain_end_busy", 32'(busy), 32'h0);
        ticks(2);
        chk("chain_idle_busy", 32'(busy), 32'h0);
        chk("chain_idle_ret", 32'(return_ctrl), 32'h6);

        // Abort mid-layer
        ctrl = 8'd0;
        tick();
        ctrl = 8'd4;
        ticks(2);
        chk("ab_run_en", 32'(layer_en), 32'h08);
        chk("ab_run_ml", 32'(mac_layer), 32'h1);
        ticks(2);
        ctrl = 8'd0;
        tick();
        chk("ab_busy", 32'(busy), 32'h0);
        chk("ab_rst", 32'(layer_rst), 32'h3f);
        chk("ab_ret", 32'(return_ctrl), 32'h0);
        chk("ab_en", 32'(layer_en), 32'h0);
        layer_done = 6'b001000;
        tick();
        layer_done = 6'd0;
        chk("ab_stray_busy", 32'(busy), 32'h0);
        chk("ab_stray_ret", 32'(return_ctrl), 32'h0);

        // Complete layer 1 so the timeout case has a nonzero return_ctrl
        ctrl = 8'd1;
        ticks(2);
        layer_done = 6'b000001;
        tick();
        layer_done = 6'd0;
        ticks(3);
        chk("l1_ret", 32'(return_ctrl), 32'h1);

        // Watchdog timeout on layer 3
        ctrl = 8'd3;
        ticks(2);
        chk("to_run_pool", 32'(pooling_layer), 32'h1);
        ticks(15);
        chk("to_last_tmo", 32'(timeout), 32'h0);
        chk("to_last_busy", 32'(busy), 32'h1);
        tick();
        chk("to_tmo", 32'(timeout), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_ret", 32'(return_ctrl), 32'h1);
        chk("to_rst", 32'(layer_rst), 32'h3f);
        chk("to_pool", 32'(pooling_layer), 32'h0);
        chk("to_en", 32'(layer_en), 32'h0);
        tick();
        chk("to_sticky", 32'(timeout), 32'h1);
        ctrl = 8'd0;
        tick();
        chk("to_clr_tmo", 32'(timeout), 32'h0);
        chk("to_clr_ret", 32'(return_ctrl), 32'h0);

        // Done on the expiry cycle wins; other layers' done ignored
        ctrl = 8'd5;
        ticks(2);
        chk("dw_run_en", 32'(layer_en), 32'h10);
        layer_done = 6'b101111;
        ticks(15);
        chk("dw_stray_en", 32'(layer_en), 32'h10);
        chk("dw_stray_busy", 32'(busy), 32'h1);
        layer_done = 6'b010000;
        tick();
        layer_done = 6'd0;
        chk("dw_flush_tmo", 32'(timeout), 32'h0);
        chk("dw_flush_busy", 32'(busy), 32'h1);
        chk("dw_flush_pool", 32'(pooling_layer), 32'h1);
        chk("dw_flush_en", 32'(layer_en), 32'h0);
        ticks(3);
        chk("dw_ret", 32'(return_ctrl), 32'h5);
        chk("dw_tmo", 32'(timeout), 32'h0);
        chk("dw_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of RUN
        ctrl = 8'd0;
        tick();
        ctrl = 8'd2;
        ticks(2);
        chk("ar_run_en", 32'(layer_en), 32'h02);
        #2 reset = 1'b0;
        #1;
        chk_rst_vals("ar_async");
        ctrl = 8'd0;
        #2 reset = 1'b1;
        tick();
        chk("ar_after_busy", 32'(busy), 32'h0);
        chk("ar_after_ret", 32'(return_ctrl), 32'h0);
        chk("ar_after_rst", 32'(layer_rst), 32'h3f);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end of stimulus, required finish before 200000");
        $fatal(1);
    end

endmodule
